// File: rtl/led_seq_decoder_pkg.sv
// Shared definitions for the LED rotation decoder.
//   state_t     : decoder FSM encoding (SYNC / TRACK / ERR)
//   DIR_UP/DOWN : dir_out encoding
//   is_onehot   : exactly-one-bit-set test on a zero-extended LED pattern
//   onehot_idx  : index of the set bit of a one-hot pattern
package led_seq_pkg;

  typedef enum logic [1:0] {
    SYNC  = 2'd0,
    TRACK = 2'd1,
    ERR   = 2'd2
  } state_t;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  // Helpers work on a fixed wide vector; callers zero-extend their bus.
  localparam int MAX_LEDS = 32;

  function automatic logic is_onehot(input logic [MAX_LEDS-1:0] p);
    return (p != '0) && ((p & (p - 1'b1)) == '0);
  endfunction

  function automatic int onehot_idx(input logic [MAX_LEDS-1:0] p);
    int idx;
    idx = 0;
    for (int i = 0; i < MAX_LEDS; i++) begin
      if (p[i]) idx = i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/led_seq_decoder_if.sv
// Bus bundle between the LED decoder and whoever observes it.
//   led_in, clr           : driven by master, sampled by slave (decoder)
//   locked .. err_cnt     : decoder results, all registered
//   state                 : debug view of the decoder FSM
// There is no handshake: led_in is sampled every clock and clr is a
// one-cycle synchronous pulse; outputs are valid every cycle.
interface led_seq_decoder_if #(
  parameter int N_LEDS = 4,
  parameter int CNT_W  = 8
) ();
  import led_seq_pkg::*;

  localparam int POS_W = (N_LEDS > 1) ? $clog2(N_LEDS) : 1;

  logic [N_LEDS-1:0] led_in;
  logic              clr;
  logic              locked;
  logic              dir_out;
  logic [POS_W-1:0]  pos_out;
  logic              step;
  logic              dir_change;
  logic              err;
  logic [CNT_W-1:0]  step_cnt;
  logic [CNT_W-1:0]  rev_cnt;
  logic [CNT_W-1:0]  err_cnt;
  state_t            state;

  modport master (
    output led_in, clr,
    input  locked, dir_out, pos_out, step, dir_change, err,
    input  step_cnt, rev_cnt, err_cnt, state
  );

  modport slave (
    input  led_in, clr,
    output locked, dir_out, pos_out, step, dir_change, err,
    output step_cnt, rev_cnt, err_cnt, state
  );

endinterface

// File: rtl/led_sat_counter.sv
// Saturating up-counter.
//   clk, rst_n : clock, asynchronous active-low reset
//   inc        : count one event (ignored once at all-ones)
//   clr        : synchronous clear, wins over inc
//   cnt        : current count
module led_sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/led_seq_decoder.sv
// Monitor for a rotating one-hot LED bus. Recovers position and direction,
// pulses on each legal step and on reversals, and flags illegal patterns
// or jumps. led_in is registered twice (led_q, led_prev); every decision
// compares those two, and results are registered, so a change seen on
// led_in shows up on the outputs two edges later.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : led_seq_decoder_if slave (led_in/clr in, results out)
module led_seq_decoder
  import led_seq_pkg::*;
#(
  parameter int N_LEDS = 4,
  parameter int CNT_W  = 8
) (
  input logic               clk,
  input logic               rst_n,
  led_seq_decoder_if.slave  bus
);

  localparam int POS_W = (N_LEDS > 1) ? $clog2(N_LEDS) : 1;

  logic [N_LEDS-1:0] led_q, led_prev;
  state_t            state, state_nx;

  logic              locked_q, locked_d;
  logic              dir_q, dir_d;
  logic [POS_W-1:0]  pos_q, pos_d;
  logic              step_q, step_d;
  logic              dchg_q, dchg_d;
  logic              err_q, err_evt;

  logic              q_valid, q_same, is_up, is_dn;
  logic [POS_W-1:0]  q_idx;

  assign q_valid = is_onehot(MAX_LEDS'(led_q));
  assign q_idx   = POS_W'(onehot_idx(MAX_LEDS'(led_q)));
  assign q_same  = (led_q == led_prev);
  assign is_up   = (led_q == {led_prev[N_LEDS-2:0], led_prev[N_LEDS-1]});
  // With two LEDs both rotations coincide; treat such moves as upward only.
  assign is_dn   = !is_up &&
                   (led_q == {led_prev[0], led_prev[N_LEDS-1:1]});

  // State and sample pipeline
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= SYNC;
      led_q    <= '0;
      led_prev <= '0;
    end else begin
      state    <= state_nx;
      led_q    <= bus.led_in;
      led_prev <= led_q;
    end
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      SYNC:    if (q_valid) state_nx = TRACK;
      TRACK:   if (!q_same && !is_up && !is_dn) state_nx = ERR;
      ERR:     if (q_same && q_valid) state_nx = TRACK;
      default: state_nx = SYNC;
    endcase
  end

  // Output logic: next values of the registered outputs
  always_comb begin
    locked_d = locked_q;
    dir_d    = dir_q;
    pos_d    = pos_q;
    step_d   = 1'b0;
    dchg_d   = 1'b0;
    err_evt  = 1'b0;
    case (state)
      SYNC: begin
        if (q_valid) begin
          locked_d = 1'b1;
          pos_d    = q_idx;
        end
      end
      TRACK: begin
        if (!q_same) begin
          if (is_up || is_dn) begin
            step_d = 1'b1;
            pos_d  = q_idx;
            dir_d  = is_up ? DIR_UP : DIR_DOWN;
            dchg_d = (dir_q != dir_d);
          end else begin
            locked_d = 1'b0;
            err_evt  = 1'b1;
          end
        end
      end
      ERR: begin
        if (q_same && q_valid) begin
          locked_d = 1'b1;
          pos_d    = q_idx;
        end
      end
      default: locked_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      locked_q <= 1'b0;
      dir_q    <= DIR_UP;
      pos_q    <= '0;
      step_q   <= 1'b0;
      dchg_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      locked_q <= locked_d;
      dir_q    <= dir_d;
      pos_q    <= pos_d;
      step_q   <= step_d;
      dchg_q   <= dchg_d;
      err_q    <= bus.clr ? 1'b0 : (err_q | err_evt);
    end
  end

  led_sat_counter #(.W(CNT_W)) u_step_cnt (
    .clk(clk), .rst_n(rst_n), .inc(step_d), .clr(bus.clr), .cnt(bus.step_cnt)
  );
  led_sat_counter #(.W(CNT_W)) u_rev_cnt (
    .clk(clk), .rst_n(rst_n), .inc(dchg_d), .clr(bus.clr), .cnt(bus.rev_cnt)
  );
  led_sat_counter #(.W(CNT_W)) u_err_cnt (
    .clk(clk), .rst_n(rst_n), .inc(err_evt), .clr(bus.clr), .cnt(bus.err_cnt)
  );

  assign bus.locked     = locked_q;
  assign bus.dir_out    = dir_q;
  assign bus.pos_out    = pos_q;
  assign bus.step       = step_q;
  assign bus.dir_change = dchg_q;
  assign bus.err        = err_q;
  assign bus.state      = state;

endmodule

// File: tb/tb_led_seq_decoder.sv
module tb_led_seq_decoder;
  import led_seq_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  led_seq_decoder_if #(.N_LEDS(4), .CNT_W(8)) bus ();

  led_seq_decoder #(.N_LEDS(4), .CNT_W(8)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  // ---------------- vector table ----------------
  typedef struct {
    logic [3:0] led;
    logic       clr;
    logic       lk;
    logic       dir;
    logic [1:0] pos;
    logic       st;
    logic       dc;
    logic       er;
    logic [7:0] sc;
    logic [7:0] rc;
    logic [7:0] ec;
    logic [1:0] fsm;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  task automatic add(input logic [3:0] led, input logic clr, input logic lk,
                     input logic dir, input logic [1:0] pos, input logic st,
                     input logic dc, input logic er, input logic [7:0] sc,
                     input logic [7:0] rc, input logic [7:0] ec,
                     input logic [1:0] fsm);
    vec_t v;
    v = '{led, clr, lk, dir, pos, st, dc, er, sc, rc, ec, fsm};
    vecs.push_back(v);
  endtask

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, " locked"},     32'(bus.locked), 0);
    chk({tag, " dir_out"},    32'(bus.dir_out), 1);
    chk({tag, " pos_out"},    32'(bus.pos_out), 0);
    chk({tag, " step"},       32'(bus.step), 0);
    chk({tag, " dir_change"}, 32'(bus.dir_change), 0);
    chk({tag, " err"},        32'(bus.err), 0);
    chk({tag, " step_cnt"},   32'(bus.step_cnt), 0);
    chk({tag, " rev_cnt"},    32'(bus.rev_cnt), 0);
    chk({tag, " err_cnt"},    32'(bus.err_cnt), 0);
    chk({tag, " state"},      32'(bus.state), 32'(SYNC));
  endtask

  // ---------------- driver ----------------
  // Inputs change on the falling edge; outputs are sampled on the next
  // falling edge, i.e. after exactly one rising edge.
  task automatic drive_cycle(input logic [3:0] led, input logic clr);
    bus.led_in = led;
    bus.clr    = clr;
    @(negedge clk);
  endtask

  logic [3:0] p;

  initial begin
    rst_n      = 1'b0;
    bus.led_in = 4'b0000;
    bus.clr    = 1'b0;

    //   led      clr lk dir pos st dc er sc  rc ec fsm
    add(4'b0001, 0, 0, 1, 0, 0, 0, 0, 0,  0, 0, 0);
    add(4'b0001, 0, 1, 1, 0, 0, 0, 0, 0,  0, 0, 1);
    add(4'b0001, 0, 1, 1, 0, 0, 0, 0, 0,  0, 0, 1);
    add(4'b0010, 0, 1, 1, 0, 0, 0, 0, 0,  0, 0, 1);
    add(4'b0010, 0, 1, 1, 1, 1, 0, 0, 1,  0, 0, 1);
    add(4'b0100, 0, 1, 1, 1, 0, 0, 0, 1,  0, 0, 1);
    add(4'b0100, 0, 1, 1, 2, 1, 0, 0, 2,  0, 0, 1);
    add(4'b1000, 0, 1, 1, 2, 0, 0, 0, 2,  0, 0, 1);
    add(4'b1000, 0, 1, 1, 3, 1, 0, 0, 3,  0, 0, 1);
    add(4'b0001, 0, 1, 1, 3, 0, 0, 0, 3,  0, 0, 1);
    add(4'b0001, 0, 1, 1, 0, 1, 0, 0, 4,  0, 0, 1); // wrap 1000->0001 up
    add(4'b0010, 0, 1, 1, 0, 0, 0, 0, 4,  0, 0, 1);
    add(4'b0010, 0, 1, 1, 1, 1, 0, 0, 5,  0, 0, 1);
    add(4'b0100, 0, 1, 1, 1, 0, 0, 0, 5,  0, 0, 1);
    add(4'b0100, 0, 1, 1, 2, 1, 0, 0, 6,  0, 0, 1);
    add(4'b0010, 0, 1, 1, 2, 0, 0, 0, 6,  0, 0, 1);
    add(4'b0010, 0, 1, 0, 1, 1, 1, 0, 7,  1, 0, 1); // reversal
    add(4'b0001, 0, 1, 0, 1, 0, 0, 0, 7,  1, 0, 1);
    add(4'b0001, 0, 1, 0, 0, 1, 0, 0, 8,  1, 0, 1);
    add(4'b1000, 0, 1, 0, 0, 0, 0, 0, 8,  1, 0, 1);
    add(4'b1000, 0, 1, 0, 3, 1, 0, 0, 9,  1, 0, 1); // wrap 0001->1000 down
    add(4'b0001, 0, 1, 0, 3, 0, 0, 0, 9,  1, 0, 1);
    add(4'b0001, 0, 1, 1, 0, 1, 1, 0, 10, 2, 0, 1); // reversal back up
    add(4'b0100, 0, 1, 1, 0, 0, 0, 0, 10, 2, 0, 1);
    add(4'b0110, 0, 0, 1, 0, 0, 0, 1, 10, 2, 1, 2); // jump 0001->0100
    add(4'b0110, 0, 0, 1, 0, 0, 0, 1, 10, 2, 1, 2); // change in ERR: no count
    add(4'b0100, 0, 0, 1, 0, 0, 0, 1, 10, 2, 1, 2); // 0110 stable but invalid
    add(4'b0100, 0, 0, 1, 0, 0, 0, 1, 10, 2, 1, 2);
    add(4'b0100, 0, 1, 1, 2, 0, 0, 1, 10, 2, 1, 1); // relock, err sticky
    add(4'b0100, 1, 1, 1, 2, 0, 0, 0, 0,  0, 0, 1); // clr
    add(4'b0100, 0, 1, 1, 2, 0, 0, 0, 0,  0, 0, 1);

    // reset checks
    @(negedge clk);
    @(negedge clk);
    chk_reset_values("in_reset");
    rst_n = 1'b1;
    @(negedge clk);
    chk_reset_values("after_release");

    // table-driven sequence
    for (int i = 0; i < vecs.size(); i++) begin
      string t;
      drive_cycle(vecs[i].led, vecs[i].clr);
      t = $sformatf("v%0d", i);
      chk({t, " locked"}, 32'(bus.locked), 32'(vecs[i].lk));
      chk({t, " dir_out"}, 32'(bus.dir_out), 32'(vecs[i].dir));
      if (vecs[i].lk) chk({t, " pos_out"}, 32'(bus.pos_out), 32'(vecs[i].pos));
      chk({t, " step"}, 32'(bus.step), 32'(vecs[i].st));
      chk({t, " dir_change"}, 32'(bus.dir_change), 32'(vecs[i].dc));
      chk({t, " err"}, 32'(bus.err), 32'(vecs[i].er));
      chk({t, " step_cnt"}, 32'(bus.step_cnt), 32'(vecs[i].sc));
      chk({t, " rev_cnt"}, 32'(bus.rev_cnt), 32'(vecs[i].rc));
      chk({t, " err_cnt"}, 32'(bus.err_cnt), 32'(vecs[i].ec));
      chk({t, " state"}, 32'(bus.state), 32'(vecs[i].fsm));
    end

    // saturation: 260 upward steps from 0100, each held two cycles
    p = 4'b0100;
    for (int i = 0; i < 260; i++) begin
      p = {p[2:0], p[3]};
      drive_cycle(p, 1'b0);
      drive_cycle(p, 1'b0);
      if (i == 9) chk("sat step_cnt after 10", 32'(bus.step_cnt), 10);
    end
    chk("sat step_cnt", 32'(bus.step_cnt), 32'hff);
    chk("sat rev_cnt", 32'(bus.rev_cnt), 0);
    chk("sat err", 32'(bus.err), 0);
    chk("sat locked", 32'(bus.locked), 1);

    // clr on the same edge as a step: clr wins
    p = {p[2:0], p[3]};
    drive_cycle(p, 1'b0);
    drive_cycle(p, 1'b1);
    chk("clr+step step", 32'(bus.step), 1);
    chk("clr+step step_cnt", 32'(bus.step_cnt), 0);
    drive_cycle(p, 1'b0);
    chk("after clr step", 32'(bus.step), 0);
    chk("after clr step_cnt", 32'(bus.step_cnt), 0);

    // one more step so the counters are non-zero before reset
    p = {p[2:0], p[3]};
    drive_cycle(p, 1'b0);
    drive_cycle(p, 1'b0);
    chk("pre-reset step_cnt", 32'(bus.step_cnt), 1);

    // mid-operation asynchronous reset, held for one cycle
    bus.led_in = 4'b0001;
    #1 rst_n = 1'b0;
    #1 chk_reset_values("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    drive_cycle(4'b0001, 1'b0);
    chk("relock edge1 locked", 32'(bus.locked), 0);
    drive_cycle(4'b0001, 1'b0);
    chk("relock edge2 locked", 32'(bus.locked), 1);
    chk("relock pos_out", 32'(bus.pos_out), 0);
    chk("relock step", 32'(bus.step), 0);
    chk("relock step_cnt", 32'(bus.step_cnt), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
